uart_tx_fifo_ctrl: RTL and testbench
====================================

Name: uart_tx_fifo_ctrl

Overview:
- 8N1 UART transmitter, counterpart of the team's 16x-oversampled UART receiver.
- `clk` runs at OVERSAMPLE x baud, and every serial bit lasts exactly OVERSAMPLE clocks.
- A small write FIFO decouples the host-side byte writer from line timing.
- Consecutive bytes go out back-to-back with no idle gap.

Parameters:
- OVERSAMPLE, 16, clocks per serial bit (>=2).
- FIFO_DEPTH, 4, byte entries in the write FIFO (power of two, >=2).
- STOP_BITS, 1, number of stop bits (1 or 2).

Ports:
- clk  in  1  system clock, OVERSAMPLE x baud.
- reset  in  1  synchronous, active-high reset.
- parallel_in  in  8  byte to transmit.
- wr_en  in  1  write strobe; `parallel_in` is pushed on the rising edge where `wr_en`=1 and `full`=0.
- full  out  1  FIFO holds FIFO_DEPTH entries (registered).
- serial_out  out  1  TX line; idles high.
- busy  out  1  high while a frame is on the line (state != IDLE).
- done  out  1  one-clock pulse at the end of each frame's last stop bit.
- err  out  1  sticky overflow flag; cleared only by reset.

Behaviour:
- Interface: one clock (`clk`); reset is synchronous and active-high (`reset`). All outputs are registered.
- Reset values: `serial_out`=1, `busy`=0, `done`=0, `err`=0, `full`=0. FIFO empty, FSM in IDLE, bit counter=0, bit index=0, shift register=0.
- Reset mid-frame: abort immediately. `serial_out` is 1 after the reset edge, the FIFO is flushed, and no `done` pulse is issued.
- FIFO push: on an edge with `wr_en`=1 and `full`=0.
- Write while full: byte is dropped and `err`<=1. A pop in the same cycle does not rescue it; `full` is evaluated before the pop.
- Simultaneous push and pop when not full: both occur and the count is unchanged.
- FIFO is first-in first-out; pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, STOP.
- IDLE: `serial_out`=1. If the FIFO is non-empty at an edge: pop the head into the shift register, clear counters, go to START, `serial_out`<=0, `busy`<=1.
- Latency: a byte written at edge k into an empty FIFO while idle is popped at edge k+1. `serial_out` falls after edge k+1.
- START: hold 0 for OVERSAMPLE clocks. Then go to DATA with `serial_out`<=data[0].
- DATA: each bit is held OVERSAMPLE clocks, LSB first. After bit 7's final clock, go to STOP with `serial_out`<=1.
- STOP: hold 1 for STOP_BITS*OVERSAMPLE clocks. On the final clock edge, `done`<=1 for exactly one cycle.
  - FIFO non-empty: pop and go directly to START (`serial_out`<=0). `busy` stays 1.
  - FIFO empty: go to IDLE and `busy`<=0.
- Frame length: exactly (9+STOP_BITS)*OVERSAMPLE clocks, i.e. 160 at the defaults. Back-to-back frames have period 160 with no extra idle clock.
- Bit counter: ceil(log2(OVERSAMPLE*STOP_BITS)) bits; wraps to 0 at each bit boundary. Bit index is 3 bits, 0..7.
- Illegal FSM encoding: return to IDLE with `serial_out`=1.
- `wr_en` is ignored while `reset`=1.

Decomposition:
- Shared package `uart_pkg`:
  - FSM state encodings (2-bit IDLE=00, START=01, DATA=10, STOP=11).
  - Default OVERSAMPLE=16.
  - Frame constants DATA_BITS=8, START_LEVEL=0, IDLE_LEVEL=1.
  - Reused by the receiver.
- Sub-module `uart_tx_fifo`:
  - Synchronous FIFO with push/pop/full/empty/count.
  - Parameter FIFO_DEPTH, width 8.
  - Same `clk`/`reset` conventions.

Test Plan:
- Reset, then write 0x55 once. `serial_out` falls 1 clock after the write edge. Line holds 0, then 1,0,1,0,1,0,1,0, then 1, each for 16 clocks. `done` pulses at clock 160 of the frame; `busy` is high for 160 clocks.
- Write 0xA3. Sampling at mid-bit (clock 8 of each bit) gives 0, 1,1,0,0,0,1,0,1, 1. `err`=0.
- Write 0x01, 0x80, 0xFF on three consecutive clocks. Three frames go out contiguously with start bits 160 clocks apart. `busy` stays high for 480 clocks and there are 3 `done` pulses.
- Write 6 bytes (0x10..0x15) on consecutive clocks with FIFO_DEPTH=4. `full` asserts. 0x10..0x14 are transmitted in order, 0x15 is dropped, and `err`=1 until reset.
- Assert `reset` during DATA bit 3 of 0xC3 with a queued byte. The next clock gives `serial_out`=1, `busy`=0, `err`=0, no `done`, and nothing further is transmitted.
- STOP_BITS=2: write 0x00. The line stays low 144 clocks, then high 32 clocks, and `done` pulses at clock 176.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encoding and frame-level constants.
// The receiver imports the same package.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_START = 2'b01,
    ST_DATA  = 2'b10,
    ST_STOP  = 2'b11
  } uart_state_e;

  localparam int   DEFAULT_OVERSAMPLE = 16;
  localparam int   DATA_BITS          = 8;
  localparam logic START_LEVEL        = 1'b0;
  localparam logic IDLE_LEVEL         = 1'b1;

endpackage

// File: rtl/uart_tx_fifo_ctrl_if.sv
// Host byte-write port and serial-line status of the UART transmitter.
interface uart_tx_fifo_ctrl_if;

  logic [7:0] parallel_in;
  logic       wr_en;
  logic       full;
  logic       serial_out;
  logic       busy;
  logic       done;
  logic       err;

  modport master (
    output parallel_in, wr_en,
    input  full, serial_out, busy, done, err
  );

  modport slave (
    input  parallel_in, wr_en,
    output full, serial_out, busy, done, err
  );

endinterface

// File: rtl/uart_tx_fifo.sv
// Byte-wide synchronous FIFO feeding the UART transmitter.
// full/empty are registered; rd_data always shows the current head entry.
module uart_tx_fifo #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] wr_data,
  output logic [7:0] rd_data,
  output logic       full,
  output logic       empty
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;
  logic             full_reg;
  logic             empty_reg;
  logic             push_ok;
  logic             pop_ok;

  // A write into a full FIFO is refused even if a pop frees a slot this cycle.
  assign push_ok = push && !full_reg;
  assign pop_ok  = pop && !empty_reg;

  always_comb begin
    count_next = count_reg;
    if (push_ok && !pop_ok) begin
      count_next = count_reg + CNT_W'(1);
    end else if (pop_ok && !push_ok) begin
      count_next = count_reg - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      full_reg   <= 1'b0;
      empty_reg  <= 1'b1;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      count_reg <= count_next;
      full_reg  <= (count_next == CNT_W'(FIFO_DEPTH));
      empty_reg <= (count_next == '0);
    end
  end

  assign rd_data = mem[rd_ptr_reg];
  assign full    = full_reg;
  assign empty   = empty_reg;

endmodule

// File: rtl/uart_tx_fifo_ctrl.sv
// 8N1 UART transmitter with a write FIFO; frames leave back-to-back,
// each bit lasting OVERSAMPLE clocks.
module uart_tx_fifo_ctrl
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE,
  parameter int FIFO_DEPTH = 4,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  uart_tx_fifo_ctrl_if.slave   tx
);

  localparam int CW = (OVERSAMPLE * STOP_BITS > 1) ? $clog2(OVERSAMPLE * STOP_BITS) : 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(OVERSAMPLE * STOP_BITS - 1);
  localparam logic [2:0]    IDX_LAST  = 3'(DATA_BITS - 1);

  uart_state_e   state_reg;
  logic [CW-1:0] bit_cnt_reg;
  logic [2:0]    bit_idx_reg;
  logic [7:0]    shift_reg;
  logic          serial_reg;
  logic          busy_reg;
  logic          done_reg;
  logic          err_reg;

  logic [7:0]    fifo_rd_data;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_pop;
  logic          stop_end;

  uart_tx_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (tx.wr_en),
    .pop     (fifo_pop),
    .wr_data (tx.parallel_in),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // The head is taken either from idle or on the last stop clock, which is
  // what makes consecutive frames abut with no idle gap.
  assign stop_end = (state_reg == ST_STOP) && (bit_cnt_reg == STOP_LAST);
  assign fifo_pop = !fifo_empty && ((state_reg == ST_IDLE) || stop_end);

  always_ff @(posedge clk) begin
    if (reset) begin
      err_reg <= 1'b0;
    end else if (tx.wr_en && fifo_full) begin
      err_reg <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      bit_cnt_reg <= '0;
      bit_idx_reg <= '0;
      shift_reg   <= '0;
      serial_reg  <= IDLE_LEVEL;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          serial_reg <= IDLE_LEVEL;
          if (!fifo_empty) begin
            shift_reg   <= fifo_rd_data;
            bit_cnt_reg <= '0;
            bit_idx_reg <= '0;
            state_reg   <= ST_START;
            serial_reg  <= START_LEVEL;
            busy_reg    <= 1'b1;
          end
        end
        ST_START: begin
          if (bit_cnt_reg == BIT_LAST) begin
            bit_cnt_reg <= '0;
            state_reg   <= ST_DATA;
            serial_reg  <= shift_reg[0];
          end else begin
            bit_cnt_reg <= bit_cnt_reg + CW'(1);
          end
        end
        ST_DATA: begin
          if (bit_cnt_reg == BIT_LAST) begin
            bit_cnt_reg <= '0;
            if (bit_idx_reg == IDX_LAST) begin
              state_reg  <= ST_STOP;
              serial_reg <= IDLE_LEVEL;
            end else begin
              // Bit 0 of the shifter is always the bit on the line.
              bit_idx_reg <= bit_idx_reg + 3'd1;
              shift_reg   <= shift_reg >> 1;
              serial_reg  <= shift_reg[1];
            end
          end else begin
            bit_cnt_reg <= bit_cnt_reg + CW'(1);
          end
        end
        ST_STOP: begin
          if (stop_end) begin
            done_reg    <= 1'b1;
            bit_cnt_reg <= '0;
            if (!fifo_empty) begin
              shift_reg   <= fifo_rd_data;
              bit_idx_reg <= '0;
              state_reg   <= ST_START;
              serial_reg  <= START_LEVEL;
            end else begin
              state_reg <= ST_IDLE;
              busy_reg  <= 1'b0;
            end
          end else begin
            bit_cnt_reg <= bit_cnt_reg + CW'(1);
          end
        end
        default: begin
          state_reg  <= ST_IDLE;
          serial_reg <= IDLE_LEVEL;
          busy_reg   <= 1'b0;
        end
      endcase
    end
  end

  assign tx.full       = fifo_full;
  assign tx.serial_out = serial_reg;
  assign tx.busy       = busy_reg;
  assign tx.done       = done_reg;
  assign tx.err        = err_reg;

endmodule

// File: tb/tb_uart_tx_fifo_ctrl.sv
// Bench for uart_tx_fifo_ctrl: a frame-timing model of the line plus a
// mid-bit line decoder; one task per scenario.
`timescale 1ns/1ps
module tb_uart_tx_fifo_ctrl;

  localparam int OS    = 16;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * OS;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  uart_tx_fifo_ctrl_if bus1 ();
  uart_tx_fifo_ctrl_if bus2 ();

  uart_tx_fifo_ctrl #(.OVERSAMPLE(OS), .FIFO_DEPTH(DEPTH), .STOP_BITS(1)) dut1 (
    .clk(clk), .reset(reset), .tx(bus1.slave)
  );
  uart_tx_fifo_ctrl #(.OVERSAMPLE(OS), .FIFO_DEPTH(DEPTH), .STOP_BITS(2)) dut2 (
    .clk(clk), .reset(reset), .tx(bus2.slave)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: pending bytes, the frame in flight and its age in clocks.
  byte unsigned mq[$];
  byte unsigned acc_q[$];
  byte unsigned rx_q[$];
  byte unsigned cur = 8'h00;
  bit           act = 1'b0;
  int           tf  = 0;
  bit           m_err  = 1'b0;
  bit           m_done = 1'b0;
  logic [4:0]   exp_v;

  logic ser_hist[$];
  logic busy_hist[$];
  logic done_hist[$];

  function automatic logic line_level();
    int b;
    if (!act) return 1'b1;
    b = tf / OS;
    if (b == 0) return 1'b0;
    if (b <= 8) return cur[b-1];
    return 1'b1;
  endfunction

  function automatic logic [4:0] obs1();
    return {bus1.serial_out, bus1.busy, bus1.done, bus1.err, bus1.full};
  endfunction

  function automatic logic [4:0] obs2();
    return {bus2.serial_out, bus2.busy, bus2.done, bus2.err, bus2.full};
  endfunction

  task automatic clear_hist();
    ser_hist.delete();
    busy_hist.delete();
    done_hist.delete();
  endtask

  // Recover bytes from the recorded line by sampling each bit at its middle.
  function automatic void decode_line();
    int i = 0;
    rx_q.delete();
    while (i + FRAME <= ser_hist.size()) begin
      if (ser_hist[i] === 1'b0) begin
        byte unsigned b = 8'h00;
        for (int k = 0; k < 8; k++) b[k] = ser_hist[i + (k + 1) * OS + OS / 2];
        rx_q.push_back(b);
        i += 9 * OS + OS / 2;
      end else begin
        i++;
      end
    end
  endfunction

  task automatic tick(input bit we, input byte unsigned d, input bit rs);
    bit full_before;
    bus1.wr_en       = we;
    bus1.parallel_in = d;
    reset            = rs;
    @(posedge clk);
    cyc++;
    full_before = (mq.size() == DEPTH);
    m_done = 1'b0;
    if (rs) begin
      mq.delete();
      act   = 1'b0;
      tf    = 0;
      m_err = 1'b0;
    end else begin
      if (act) begin
        tf++;
        if (tf == FRAME) begin
          m_done = 1'b1;
          if (mq.size() > 0) begin
            cur = mq.pop_front();
            tf  = 0;
          end else begin
            act = 1'b0;
          end
        end
      end else if (mq.size() > 0) begin
        cur = mq.pop_front();
        act = 1'b1;
        tf  = 0;
      end
      if (we) begin
        if (full_before) begin
          m_err = 1'b1;
        end else begin
          mq.push_back(d);
          acc_q.push_back(d);
        end
      end
    end
    exp_v = {line_level(), act, m_done, m_err, (mq.size() == DEPTH)};
    #1;
    ser_hist.push_back(bus1.serial_out);
    busy_hist.push_back(bus1.busy);
    done_hist.push_back(bus1.done);
    if (m_done) $display("frame complete cyc=%0d", cyc);
  endtask

  task automatic test_reset();
    bus2.wr_en = 1'b0;
    bus2.parallel_in = 8'h00;
    tick(1'b1, 8'hEE, 1'b1);
    tick(1'b1, 8'hEE, 1'b1);
    total++;
    if (obs1() !== 5'b10000) begin
      bad++; $display("FAIL reset_dut1 got=%b want=%b", obs1(), 5'b10000);
    end
    total++;
    if (obs2() !== 5'b10000) begin
      bad++; $display("FAIL reset_dut2 got=%b want=%b", obs2(), 5'b10000);
    end
    for (int j = 0; j < 20; j++) begin
      tick(1'b0, 8'h00, 1'b0);
      total++;
      if (obs1() !== exp_v) begin
        bad++; $display("FAIL reset_model cyc=%0d got=%b want=%b", cyc, obs1(), exp_v);
      end
    end
  endtask

  task automatic test_single_frame();
    logic [9:0] want = 10'b1010101010;
    int busy_n = 0;
    int done_n = 0;
    int done_at = -1;
    bit level_ok = 1'b1;
    tick(1'b1, 8'h55, 1'b0);
    total++;
    if (bus1.serial_out !== 1'b1) begin
      bad++; $display("FAIL single_write_edge got=%b want=1", bus1.serial_out);
    end
    clear_hist();
    for (int j = 0; j < FRAME + 10; j++) begin
      tick(1'b0, 8'h00, 1'b0);
      total++;
      if (obs1() !== exp_v) begin
        bad++; $display("FAIL single_model cyc=%0d got=%b want=%b", cyc, obs1(), exp_v);
      end
    end
    for (int j = 0; j < FRAME + 10; j++) begin
      if (busy_hist[j] === 1'b1) busy_n++;
      if (done_hist[j] === 1'b1) begin done_n++; done_at = j; end
    end
    for (int b = 0; b < 10; b++)
      for (int s = 0; s < OS; s++)
        if (ser_hist[b * OS + s] !== want[b]) level_ok = 1'b0;
    total++;
    if (!level_ok) begin
      bad++; $display("FAIL single_levels got=mismatched want=0x55 bit pattern");
    end
    total++;
    if (busy_n != FRAME) begin
      bad++; $display("FAIL single_busy_len got=%0d want=%0d", busy_n, FRAME);
    end
    total++;
    if (done_n != 1 || done_at != FRAME) begin
      bad++; $display("FAIL single_done got=%0d@%0d want=1@%0d", done_n, done_at, FRAME);
    end
  endtask

  task automatic test_mid_bit();
    logic [9:0] want = 10'b1101000110;
    logic [9:0] got;
    clear_hist();
    tick(1'b1, 8'hA3, 1'b0);
    for (int j = 0; j < FRAME + 10; j++) begin
      tick(1'b0, 8'h00, 1'b0);
      total++;
      if (obs1() !== exp_v) begin
        bad++; $display("FAIL midbit_model cyc=%0d got=%b want=%b", cyc, obs1(), exp_v);
      end
    end
    for (int b = 0; b < 10; b++) got[b] = ser_hist[1 + b * OS + OS / 2];
    total++;
    if (got !== want) begin
      bad++; $display("FAIL midbit_samples got=%b want=%b", got, want);
    end
    total++;
    if (bus1.err !== 1'b0) begin
      bad++; $display("FAIL midbit_err got=%b want=0", bus1.err);
    end
  endtask

  task automatic test_back_to_back();
    byte unsigned want[3] = '{8'h01, 8'h80, 8'hFF};
    int busy_n = 0;
    int done_pos[$];
    clear_hist();
    for (int k = 0; k < 3; k++) tick(1'b1, want[k], 1'b0);
    for (int j = 0; j < 3 * FRAME + 20; j++) begin
      tick(1'b0, 8'h00, 1'b0);
      total++;
      if (obs1() !== exp_v) begin
        bad++; $display("FAIL b2b_model cyc=%0d got=%b want=%b", cyc, obs1(), exp_v);
      end
    end
    for (int j = 0; j < ser_hist.size(); j++) begin
      if (busy_hist[j] === 1'b1) busy_n++;
      if (done_hist[j] === 1'b1) done_pos.push_back(j);
    end
    total++;
    if (busy_n != 3 * FRAME) begin
      bad++; $display("FAIL b2b_busy_len got=%0d want=%0d", busy_n, 3 * FRAME);
    end
    total++;
    if (done_pos.size() != 3) begin
      bad++; $display("FAIL b2b_done_count got=%0d want=3", done_pos.size());
    end else if (done_pos[1] - done_pos[0] != FRAME || done_pos[2] - done_pos[1] != FRAME) begin
      bad++; $display("FAIL b2b_done_spacing got=%0d,%0d want=%0d", done_pos[1] - done_pos[0],
                      done_pos[2] - done_pos[1], FRAME);
    end
    decode_line();
    total++;
    if (rx_q.size() != 3 || rx_q[0] != want[0] || rx_q[1] != want[1] || rx_q[2] != want[2]) begin
      bad++; $display("FAIL b2b_bytes got_n=%0d want=01,80,FF", rx_q.size());
    end
  endtask

  task automatic test_overflow();
    bit bytes_ok;
    clear_hist();
    for (int k = 0; k < 6; k++) begin
      tick(1'b1, 8'(8'h10 + k), 1'b0);
      if (k == 4) begin
        total++;
        if (bus1.full !== 1'b1) begin
          bad++; $display("FAIL ovf_full got=%b want=1", bus1.full);
        end
      end
    end
    total++;
    if (bus1.err !== 1'b1) begin
      bad++; $display("FAIL ovf_err got=%b want=1", bus1.err);
    end
    for (int j = 0; j < 5 * FRAME + 20; j++) begin
      tick(1'b0, 8'h00, 1'b0);
      total++;
      if (obs1() !== exp_v) begin
        bad++; $display("FAIL ovf_model cyc=%0d got=%b want=%b", cyc, obs1(), exp_v);
      end
    end
    decode_line();
    bytes_ok = (rx_q.size() == 5);
    for (int k = 0; k < 5 && bytes_ok; k++) if (rx_q[k] != 8'(8'h10 + k)) bytes_ok = 1'b0;
    total++;
    if (!bytes_ok) begin
      bad++; $display("FAIL ovf_bytes got_n=%0d want=10..14", rx_q.size());
    end
    total++;
    if (bus1.err !== 1'b1) begin
      bad++; $display("FAIL ovf_err_sticky got=%b want=1", bus1.err);
    end
  endtask

  task automatic test_reset_mid_frame();
    bit quiet = 1'b1;
    tick(1'b1, 8'hC3, 1'b0);
    tick(1'b1, 8'h5A, 1'b0);
    // Pop happened on the second tick; land inside data bit 3.
    for (int j = 0; j < 4 * OS + 6; j++) begin
      tick(1'b0, 8'h00, 1'b0);
      total++;
      if (obs1() !== exp_v) begin
        bad++; $display("FAIL rstmid_model cyc=%0d got=%b want=%b", cyc, obs1(), exp_v);
      end
    end
    tick(1'b0, 8'h00, 1'b1);
    total++;
    if (obs1() !== 5'b10000) begin
      bad++; $display("FAIL rstmid_after_reset got=%b want=%b", obs1(), 5'b10000);
    end
    for (int j = 0; j < 2 * FRAME; j++) begin
      tick(1'b0, 8'h00, 1'b0);
      if (bus1.serial_out !== 1'b1 || bus1.busy !== 1'b0 || bus1.done !== 1'b0) quiet = 1'b0;
    end
    total++;
    if (!quiet) begin
      bad++; $display("FAIL rstmid_quiet got=activity want=idle line");
    end
  endtask

  task automatic test_two_stop_bits();
    logic s2[$];
    logic b2[$];
    logic d2[$];
    bit low_ok = 1'b1;
    bit high_ok = 1'b1;
    int busy_n = 0;
    int done_n = 0;
    int done_at = -1;
    bus2.wr_en = 1'b1;
    bus2.parallel_in = 8'h00;
    tick(1'b0, 8'h00, 1'b0);
    bus2.wr_en = 1'b0;
    for (int j = 0; j < 200; j++) begin
      tick(1'b0, 8'h00, 1'b0);
      s2.push_back(bus2.serial_out);
      b2.push_back(bus2.busy);
      d2.push_back(bus2.done);
    end
    for (int j = 0; j < 144; j++) if (s2[j] !== 1'b0) low_ok = 1'b0;
    for (int j = 144; j < 200; j++) if (s2[j] !== 1'b1) high_ok = 1'b0;
    for (int j = 0; j < 200; j++) begin
      if (b2[j] === 1'b1) busy_n++;
      if (d2[j] === 1'b1) begin done_n++; done_at = j; end
    end
    total++;
    if (!low_ok) begin
      bad++; $display("FAIL sb2_low got=not low for 144 want=low 144");
    end
    total++;
    if (!high_ok) begin
      bad++; $display("FAIL sb2_high got=not high after 144 want=high");
    end
    total++;
    if (done_n != 1 || done_at != 176) begin
      bad++; $display("FAIL sb2_done got=%0d@%0d want=1@176", done_n, done_at);
    end
    total++;
    if (busy_n != 176) begin
      bad++; $display("FAIL sb2_busy_len got=%0d want=176", busy_n);
    end
  endtask

  task automatic test_random();
    bit bytes_ok;
    tick(1'b0, 8'h00, 1'b1);
    acc_q.delete();
    clear_hist();
    for (int j = 0; j < 4000; j++) begin
      int rate = ((j / 1000) % 2 == 0) ? 1 : 8;
      bit we = ($urandom_range(0, 99) < rate);
      tick(we, 8'($urandom), 1'b0);
      total++;
      if (obs1() !== exp_v) begin
        bad++; $display("FAIL rand_model cyc=%0d got=%b want=%b", cyc, obs1(), exp_v);
      end
    end
    for (int j = 0; j < (DEPTH + 2) * FRAME; j++) begin
      tick(1'b0, 8'h00, 1'b0);
      total++;
      if (obs1() !== exp_v) begin
        bad++; $display("FAIL rand_drain cyc=%0d got=%b want=%b", cyc, obs1(), exp_v);
      end
    end
    decode_line();
    bytes_ok = (rx_q.size() == acc_q.size());
    for (int k = 0; k < rx_q.size() && bytes_ok; k++) if (rx_q[k] != acc_q[k]) bytes_ok = 1'b0;
    total++;
    if (!bytes_ok) begin
      bad++; $display("FAIL rand_bytes got_n=%0d want_n=%0d", rx_q.size(), acc_q.size());
    end
  endtask

  initial begin
    bus1.wr_en = 1'b0;
    bus1.parallel_in = 8'h00;
    bus2.wr_en = 1'b0;
    bus2.parallel_in = 8'h00;
    test_reset();
    test_single_frame();
    test_mid_bit();
    test_back_to_back();
    test_overflow();
    test_reset_mid_frame();
    test_two_stop_bits();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d want=finish before timeout", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
